pong_game: RTL and testbench

- Game-logic stage directly upstream of the VGA renderer.
- Once per video frame it updates both paddle positions from player buttons, moves the ball, handles wall and paddle bounces, and keeps the score.
- Drives the renderer's paddle/ball bounding-box inputs (xmin/xmax/ymin/ymax) and the per-player scores.
- All updates land at the start of vertical sync, inside vertical blank, so the renderer never sees a mid-frame change.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_paddle.sv | 50 +++++
 rtl/pong_game.sv | 248 ++++++++++++++++++++++++
 tb/tb_pong_game.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared screen geometry, coordinate widths and game state encoding for the
// pong game logic.
package pong_pkg;

  localparam int SCREEN_WIDTH  = 400;
  localparam int SCREEN_HEIGHT = 600;
  localparam int WRES_BITS     = $clog2(SCREEN_WIDTH);
  localparam int HRES_BITS     = $clog2(SCREEN_HEIGHT);

  localparam int PADDLE_W  = 8;
  localparam int PADDLE_H  = 80;
  localparam int BALL_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_DELAY,
    PLAY,
    POINT,
    GAMEOVER
  } game_state_e;

endpackage

// File: rtl/pong_paddle.sv
// Saturating vertical paddle position; moves one step per enabled frame while
// exactly one of up/down is held.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int SPEED   = 6,
  parameter int RESET_Y = (SCREEN_HEIGHT - PADDLE_H) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_en,
  input  logic                 up,
  input  logic                 down,
  output logic [HRES_BITS-1:0] ymin,
  output logic [HRES_BITS-1:0] ymax
);

  localparam logic [HRES_BITS-1:0] STEP     = HRES_BITS'(SPEED);
  localparam logic [HRES_BITS-1:0] Y_TOP    = HRES_BITS'(SCREEN_HEIGHT - PADDLE_H);
  localparam logic [HRES_BITS-1:0] DOWN_LIM = HRES_BITS'(SCREEN_HEIGHT - PADDLE_H - SPEED);
  localparam logic [HRES_BITS-1:0] H_M1     = HRES_BITS'(PADDLE_H - 1);
  localparam logic [HRES_BITS-1:0] Y_RST    = HRES_BITS'(RESET_Y);

  logic [HRES_BITS-1:0] ymin_q, ymin_d;
  logic [HRES_BITS-1:0] ymax_q, ymax_d;

  always_comb begin
    ymin_d = ymin_q;
    if (step_en && up && !down) begin
      ymin_d = (ymin_q < STEP) ? '0 : ymin_q - STEP;
    end else if (step_en && down && !up) begin
      ymin_d = (ymin_q > DOWN_LIM) ? Y_TOP : ymin_q + STEP;
    end
    ymax_d = ymin_d + H_M1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ymin_q <= Y_RST;
      ymax_q <= Y_RST + H_M1;
    end else begin
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  assign ymin = ymin_q;
  assign ymax = ymax_q;

endmodule

// File: rtl/pong_game.sv
// Per-frame pong game logic feeding the VGA renderer's bounding boxes and scores.
// Define PONG_AI_EN to let the right paddle track the ball instead of its buttons.
module pong_game
  import pong_pkg::*;
#(
  parameter int PADDLE_X_OFFSET = 16,
  parameter int PADDLE_SPEED    = 6,
  parameter int BALL_SPEED      = 3,
  parameter int SERVE_FRAMES    = 60,
  parameter int WIN_SCORE       = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync,
  input  logic                 serve,
  input  logic                 left_up,
  input  logic                 left_down,
  input  logic                 right_up,
  input  logic                 right_down,
  output logic [WRES_BITS-1:0] paddleleft_xmin,
  output logic [WRES_BITS-1:0] paddleleft_xmax,
  output logic [HRES_BITS-1:0] paddleleft_ymin,
  output logic [HRES_BITS-1:0] paddleleft_ymax,
  output logic [WRES_BITS-1:0] paddleright_xmin,
  output logic [WRES_BITS-1:0] paddleright_xmax,
  output logic [HRES_BITS-1:0] paddleright_ymin,
  output logic [HRES_BITS-1:0] paddleright_ymax,
  output logic [WRES_BITS-1:0] ball_xmin,
  output logic [WRES_BITS-1:0] ball_xmax,
  output logic [HRES_BITS-1:0] ball_ymin,
  output logic [HRES_BITS-1:0] ball_ymax,
  output logic [3:0]           score_left,
  output logic [3:0]           score_right,
  output logic                 game_over
);

  localparam int XW = WRES_BITS + 1;
  localparam int YW = HRES_BITS + 1;
  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [WRES_BITS-1:0] BALL_X0   = WRES_BITS'((SCREEN_WIDTH - BALL_SIZE) / 2);
  localparam logic [HRES_BITS-1:0] BALL_Y0   = HRES_BITS'((SCREEN_HEIGHT - BALL_SIZE) / 2);
  localparam logic [WRES_BITS-1:0] BALL_XM1  = WRES_BITS'(BALL_SIZE - 1);
  localparam logic [HRES_BITS-1:0] BALL_YM1  = HRES_BITS'(BALL_SIZE - 1);
  localparam logic [WRES_BITS-1:0] BX_LHIT   = WRES_BITS'(PADDLE_X_OFFSET + PADDLE_W);
  localparam logic signed [XW-1:0] SPD_X     = XW'(BALL_SPEED);
  localparam logic signed [YW-1:0] SPD_Y     = YW'(BALL_SPEED);
  localparam logic signed [XW-1:0] X_LHIT    = XW'(PADDLE_X_OFFSET + PADDLE_W - 1);
  localparam logic signed [XW-1:0] X_RHIT    = XW'(SCREEN_WIDTH - PADDLE_X_OFFSET - PADDLE_W - BALL_SIZE);
  localparam logic signed [XW-1:0] X_MAX     = XW'(SCREEN_WIDTH - BALL_SIZE);
  localparam logic signed [YW-1:0] Y_MAX     = YW'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic [CW-1:0]        CNT_LAST  = CW'(SERVE_FRAMES - 1);
  localparam logic [3:0]           WIN       = 4'(WIN_SCORE);

  logic vsync_q, vsync_qq, serve_q, serve_qq;
  logic tick, serve_edge, paddle_step;
  logic right_up_eff, right_down_eff;

  game_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WRES_BITS-1:0]  ball_x_q, ball_x_d, ball_xmax_q, ball_xmax_d;
  logic [HRES_BITS-1:0]  ball_y_q, ball_y_d, ball_ymax_q, ball_ymax_d;
  logic                  dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [3:0]            score_l_q, score_l_d, score_r_q, score_r_d;
  logic                  game_over_q, game_over_d;

  logic signed [XW-1:0]  bx_s, nx;
  logic signed [YW-1:0]  by_s, ny;
  logic [HRES_BITS-1:0]  by_new, by_new_max;
  logic                  wall_dy_neg, hit_left, hit_right, miss_left, miss_right;

  assign tick        = vsync_qq & ~vsync_q;
  assign serve_edge  = serve_q & ~serve_qq;
  assign paddle_step = tick && (state_q != GAMEOVER);

`ifdef PONG_AI_EN
  logic [HRES_BITS-1:0] ball_mid, pad_mid;
  assign ball_mid       = ball_y_q + HRES_BITS'(BALL_SIZE / 2);
  assign pad_mid        = paddleright_ymin + HRES_BITS'(PADDLE_H / 2);
  assign right_up_eff   = (ball_mid + HRES_BITS'(4)) < pad_mid;
  assign right_down_eff = ball_mid > (pad_mid + HRES_BITS'(4));
`else
  assign right_up_eff   = right_up;
  assign right_down_eff = right_down;
`endif

  pong_paddle #(.SPEED(PADDLE_SPEED)) u_paddle_left (
    .clk(clk), .rst(rst), .step_en(paddle_step), .up(left_up), .down(left_down),
    .ymin(paddleleft_ymin), .ymax(paddleleft_ymax)
  );

  pong_paddle #(.SPEED(PADDLE_SPEED)) u_paddle_right (
    .clk(clk), .rst(rst), .step_en(paddle_step), .up(right_up_eff), .down(right_down_eff),
    .ymin(paddleright_ymin), .ymax(paddleright_ymax)
  );

  // Candidate ball move; overlap uses the wall-corrected y against the paddles as they stood before this frame.
  always_comb begin
    bx_s        = $signed({1'b0, ball_x_q});
    by_s        = $signed({1'b0, ball_y_q});
    nx          = dx_neg_q ? bx_s - SPD_X : bx_s + SPD_X;
    ny          = dy_neg_q ? by_s - SPD_Y : by_s + SPD_Y;
    wall_dy_neg = dy_neg_q;
    if (ny[YW-1]) begin
      by_new      = '0;
      wall_dy_neg = 1'b0;
    end else if (ny > Y_MAX) begin
      by_new      = Y_MAX[HRES_BITS-1:0];
      wall_dy_neg = 1'b1;
    end else begin
      by_new = ny[HRES_BITS-1:0];
    end
    by_new_max = by_new + BALL_YM1;
    hit_left   = dx_neg_q && (bx_s > X_LHIT) && (nx <= X_LHIT)
                 && (by_new <= paddleleft_ymax) && (by_new_max >= paddleleft_ymin);
    hit_right  = !dx_neg_q && (bx_s <= X_RHIT) && (nx > X_RHIT)
                 && (by_new <= paddleright_ymax) && (by_new_max >= paddleright_ymin);
    miss_left  = nx[XW-1] && !hit_left;
    miss_right = (nx > X_MAX) && !hit_right;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (tick) begin
      unique case (state_q)
        SERVE_DELAY: begin
          if (cnt_q == CNT_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PLAY: begin
          ball_y_d = by_new;
          dy_neg_d = wall_dy_neg;
          if (hit_left) begin
            ball_x_d = BX_LHIT;
            dx_neg_d = 1'b0;
          end else if (hit_right) begin
            ball_x_d = X_RHIT[WRES_BITS-1:0];
            dx_neg_d = 1'b1;
          end else if (miss_left) begin
            ball_x_d  = '0;
            dx_neg_d  = 1'b1;
            score_r_d = score_r_q + 4'd1;
            state_d   = POINT;
            cnt_d     = '0;
          end else if (miss_right) begin
            ball_x_d  = X_MAX[WRES_BITS-1:0];
            dx_neg_d  = 1'b0;
            score_l_d = score_l_q + 4'd1;
            state_d   = POINT;
            cnt_d     = '0;
          end else begin
            ball_x_d = nx[WRES_BITS-1:0];
          end
        end
        POINT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (score_l_q == WIN || score_r_q == WIN) begin
              state_d = GAMEOVER;
            end else begin
              state_d  = SERVE_DELAY;
              ball_x_d = BALL_X0;
              ball_y_d = BALL_Y0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
    // A serve arriving with a tick overrides only the state the tick left behind.
    if (serve_edge && state_q == IDLE) begin
      state_d = SERVE_DELAY;
      cnt_d   = '0;
    end else if (serve_edge && state_q == GAMEOVER) begin
      state_d   = SERVE_DELAY;
      cnt_d     = '0;
      score_l_d = '0;
      score_r_d = '0;
      ball_x_d  = BALL_X0;
      ball_y_d  = BALL_Y0;
    end
    ball_xmax_d = ball_x_d + BALL_XM1;
    ball_ymax_d = ball_y_d + BALL_YM1;
    game_over_d = (state_d == GAMEOVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b1;
      vsync_qq    <= 1'b1;
      serve_q     <= 1'b0;
      serve_qq    <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      ball_xmax_q <= BALL_X0 + BALL_XM1;
      ball_ymax_q <= BALL_Y0 + BALL_YM1;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      vsync_qq    <= vsync_q;
      serve_q     <= serve;
      serve_qq    <= serve_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      ball_xmax_q <= ball_xmax_d;
      ball_ymax_q <= ball_ymax_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
    end
  end

  assign paddleleft_xmin  = WRES_BITS'(PADDLE_X_OFFSET);
  assign paddleleft_xmax  = WRES_BITS'(PADDLE_X_OFFSET + PADDLE_W - 1);
  assign paddleright_xmin = WRES_BITS'(SCREEN_WIDTH - PADDLE_X_OFFSET - PADDLE_W);
  assign paddleright_xmax = WRES_BITS'(SCREEN_WIDTH - PADDLE_X_OFFSET - 1);
  assign ball_xmin        = ball_x_q;
  assign ball_xmax        = ball_xmax_q;
  assign ball_ymin        = ball_y_q;
  assign ball_ymax        = ball_ymax_q;
  assign score_left       = score_l_q;
  assign score_right      = score_r_q;
  assign game_over        = game_over_q;

endmodule

// File: tb/tb_pong_game.sv
// Randomized bench for pong_game: every frame is compared against a
// frame-level integer model of the game rules.
`timescale 1ns/1ps
module tb_pong_game;

  logic clk = 1'b0;
  logic rst, vsync, serve, leftUp, leftDown, rightUp, rightDown;
  logic [8:0] plXmin, plXmax, prXmin, prXmax, bXmin, bXmax;
  logic [9:0] plYmin, plYmax, prYmin, prYmax, bYmin, bYmax;
  logic [3:0] scoreL, scoreR;
  logic       gameOver;

  int compareCount  = 0;
  int mismatchCount = 0;

  int    mLeftY, mRightY, mBallX, mBallY, mDirX, mDirY, mScoreL, mScoreR, mFrames;
  string mMode;

  always #5 clk = ~clk;

  pong_game dut (
    .clk(clk), .rst(rst), .vsync(vsync), .serve(serve),
    .left_up(leftUp), .left_down(leftDown), .right_up(rightUp), .right_down(rightDown),
    .paddleleft_xmin(plXmin), .paddleleft_xmax(plXmax),
    .paddleleft_ymin(plYmin), .paddleleft_ymax(plYmax),
    .paddleright_xmin(prXmin), .paddleright_xmax(prXmax),
    .paddleright_ymin(prYmin), .paddleright_ymax(prYmax),
    .ball_xmin(bXmin), .ball_xmax(bXmax), .ball_ymin(bYmin), .ball_ymax(bYmax),
    .score_left(scoreL), .score_right(scoreR), .game_over(gameOver)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    compareCount++;
    if (observed !== 32'(expected)) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, ":pl_xmin"}, 32'(plXmin), 16);
    checkOutput({phase, ":pl_xmax"}, 32'(plXmax), 23);
    checkOutput({phase, ":pr_xmin"}, 32'(prXmin), 376);
    checkOutput({phase, ":pr_xmax"}, 32'(prXmax), 383);
    checkOutput({phase, ":pl_ymin"}, 32'(plYmin), mLeftY);
    checkOutput({phase, ":pl_ymax"}, 32'(plYmax), mLeftY + 79);
    checkOutput({phase, ":pr_ymin"}, 32'(prYmin), mRightY);
    checkOutput({phase, ":pr_ymax"}, 32'(prYmax), mRightY + 79);
    checkOutput({phase, ":ball_xmin"}, 32'(bXmin), mBallX);
    checkOutput({phase, ":ball_xmax"}, 32'(bXmax), mBallX + 7);
    checkOutput({phase, ":ball_ymin"}, 32'(bYmin), mBallY);
    checkOutput({phase, ":ball_ymax"}, 32'(bYmax), mBallY + 7);
    checkOutput({phase, ":score_l"}, 32'(scoreL), mScoreL);
    checkOutput({phase, ":score_r"}, 32'(scoreR), mScoreR);
    checkOutput({phase, ":game_over"}, 32'(gameOver), (mMode == "OVER") ? 1 : 0);
  endtask

  function automatic void modelReset();
    mLeftY = 260; mRightY = 260;
    mBallX = 196; mBallY = 296;
    mDirX = 1; mDirY = 1;
    mScoreL = 0; mScoreR = 0;
    mFrames = 0; mMode = "IDLE";
  endfunction

  function automatic int movePaddle(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 6 < 0) ? 0 : y - 6;
    if (dn && !up) return (y + 6 > 520) ? 520 : y + 6;
    return y;
  endfunction

  function automatic bit overlaps(input int ballY, input int padY);
    return (ballY <= padY + 79) && (ballY + 7 >= padY);
  endfunction

  // One frame of play: integer positions, direction as +/-1.
  function automatic void moveBall();
    int nx, ny;
    nx = mBallX + 3 * mDirX;
    ny = mBallY + 3 * mDirY;
    if (ny < 0) begin ny = 0; mDirY = 1; end
    else if (ny > 592) begin ny = 592; mDirY = -1; end
    mBallY = ny;
    if (mDirX < 0 && mBallX >= 24 && nx <= 23 && overlaps(ny, mLeftY)) begin
      mBallX = 24; mDirX = 1;
    end else if (mDirX > 0 && mBallX + 7 < 376 && nx + 7 >= 376 && overlaps(ny, mRightY)) begin
      mBallX = 368; mDirX = -1;
    end else if (nx < 0) begin
      mBallX = 0; mDirX = -1; mScoreR++; mMode = "POINT"; mFrames = 0;
    end else if (nx > 392) begin
      mBallX = 392; mDirX = 1; mScoreL++; mMode = "POINT"; mFrames = 0;
    end else begin
      mBallX = nx;
    end
  endfunction

  function automatic void modelTick(input bit lu, input bit ld, input bit ru, input bit rd);
    if (mMode == "OVER") return;
    if (mMode == "DELAY") begin
      mFrames++;
      if (mFrames == 60) begin mMode = "PLAY"; mFrames = 0; end
    end else if (mMode == "PLAY") begin
      moveBall();
    end else if (mMode == "POINT") begin
      mFrames++;
      if (mFrames == 60) begin
        mFrames = 0;
        if (mScoreL == 9 || mScoreR == 9) mMode = "OVER";
        else begin mMode = "DELAY"; mBallX = 196; mBallY = 296; end
      end
    end
    mLeftY  = movePaddle(mLeftY, lu, ld);
    mRightY = movePaddle(mRightY, ru, rd);
  endfunction

  function automatic void modelServe();
    if (mMode == "IDLE") begin
      mMode = "DELAY"; mFrames = 0;
    end else if (mMode == "OVER") begin
      mMode = "DELAY"; mFrames = 0;
      mScoreL = 0; mScoreR = 0; mBallX = 196; mBallY = 296;
    end
  endfunction

  task automatic applyStimulus(input bit lu, input bit ld, input bit ru, input bit rd, input string phase);
    @(negedge clk);
    leftUp = lu; leftDown = ld; rightUp = ru; rightDown = rd;
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    modelTick(lu, ld, ru, rd);
    checkAll(phase);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pressServe(input string phase);
    @(negedge clk);
    serve = 1'b1;
    repeat (3) @(negedge clk);
    serve = 1'b0;
    repeat (3) @(negedge clk);
    modelServe();
    checkAll(phase);
  endtask

  initial begin
    bit lu, ld, ru, rd;
    rst = 1'b0; vsync = 1'b1; serve = 1'b0;
    leftUp = 1'b0; leftDown = 1'b0; rightUp = 1'b0; rightDown = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, "idle");
    for (int i = 0; i < 50; i++) applyStimulus(1, 0, 0, 0, "left_up");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, "both");
    for (int i = 0; i < 100; i++) applyStimulus(0, 1, 0, 1, "down_sat");
    for (int i = 0; i < 20; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), "idle_rand");

    pressServe("serve");
    for (int f = 0; f < 9000 && mMode != "OVER"; f++) begin
      lu = $urandom_range(0, 1);
      ld = $urandom_range(0, 1);
      if ($urandom_range(0, 3) != 0) begin
        ru = (mBallY + 4) < (mRightY + 38);
        rd = (mBallY + 4) > (mRightY + 42);
      end else begin
        ru = $urandom_range(0, 1);
        rd = $urandom_range(0, 1);
      end
      applyStimulus(lu, ld, ru, rd, "game");
    end
    checkOutput("reached_game_over", 32'(gameOver), 1);

    for (int i = 0; i < 5; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), "over_hold");
    pressServe("restart");
    for (int i = 0; i < 66; i++) applyStimulus(0, 0, 0, 0, "replay");

    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    modelReset();
    checkAll("async_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
